// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with a lead-adjusted pixel request and registered sync/de/RGB outputs.
// Optional build macro VGA_TEST_PATTERN_EN adds pat_en and an internal 8-bar RGB565 test pattern.

module vga_timing_gen #(
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_BACK  = 48,
    parameter int unsigned H_VALID = 640,
    parameter int unsigned H_FRONT = 16,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BACK  = 33,
    parameter int unsigned V_VALID = 480,
    parameter int unsigned V_FRONT = 10,
    parameter bit          HS_POL  = 1'b0,
    parameter bit          VS_POL  = 1'b0,
    parameter int unsigned LEAD    = 1,
    parameter int unsigned RGB_W   = 16,
    parameter int unsigned CNT_W   = 12
) (
    input  logic             vga_clk,
    input  logic             sys_rst_n,
`ifdef VGA_TEST_PATTERN_EN
    input  logic             pat_en,
`endif
    input  logic [RGB_W-1:0] pix_data,
    output logic             pix_req,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [RGB_W-1:0] rgb,
    output logic             frame_start
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
    localparam int unsigned HA      = H_SYNC + H_BACK;
    localparam int unsigned VA      = V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_LAST_C = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST_C = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] HS_END_C = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] VS_END_C = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] HA_C     = CNT_W'(HA);
    localparam logic [CNT_W-1:0] HE_C     = CNT_W'(HA + H_VALID);
    localparam logic [CNT_W-1:0] VA_C     = CNT_W'(VA);
    localparam logic [CNT_W-1:0] VE_C     = CNT_W'(VA + V_VALID);
    localparam logic [CNT_W-1:0] REQ_LO_C = CNT_W'(HA - LEAD);
    localparam logic [CNT_W-1:0] REQ_HI_C = CNT_W'(HA + H_VALID - 1 - LEAD);

    generate
        if (LEAD > 4) begin : g_err_lead_range
            $error("vga_timing_gen: LEAD must be in 0..4");
        end
        if (LEAD > HA) begin : g_err_lead_porch
            $error("vga_timing_gen: LEAD must not exceed H_SYNC+H_BACK");
        end
        if (64'(H_TOTAL) >= (64'd1 << CNT_W)) begin : g_err_h_total
            $error("vga_timing_gen: H_TOTAL does not fit in CNT_W");
        end
        if (64'(V_TOTAL) >= (64'd1 << CNT_W)) begin : g_err_v_total
            $error("vga_timing_gen: V_TOTAL does not fit in CNT_W");
        end
`ifdef VGA_TEST_PATTERN_EN
        if (RGB_W != 16) begin : g_err_pat_width
            $error("vga_timing_gen: test pattern needs RGB_W=16");
        end
        if (H_VALID < 8) begin : g_err_pat_bars
            $error("vga_timing_gen: test pattern needs H_VALID >= 8");
        end
`endif
    endgenerate

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             de_q, de_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             frame_start_q, frame_start_d;
    logic             h_wrap;
    logic             req_h, req_v;

    always_comb begin
        h_wrap  = (h_cnt_q == H_LAST_C);
        h_cnt_d = h_wrap ? '0 : h_cnt_q + CNT_W'(1);
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = (v_cnt_q == V_LAST_C) ? '0 : v_cnt_q + CNT_W'(1);
        end
    end

    // Request leads de by LEAD cycles; reset gating keeps it quiet while counters are held.
    always_comb begin
        req_h   = (h_cnt_q >= REQ_LO_C) && (h_cnt_q <= REQ_HI_C);
        req_v   = (v_cnt_q >= VA_C) && (v_cnt_q < VE_C);
        pix_req = sys_rst_n && req_h && req_v;
        pix_x   = pix_req ? (h_cnt_q - REQ_LO_C) : '0;
        pix_y   = pix_req ? (v_cnt_q - VA_C) : '0;
    end

    always_comb begin
        hsync_d       = (h_cnt_q < HS_END_C) ? HS_POL : ~HS_POL;
        vsync_d       = (v_cnt_q < VS_END_C) ? VS_POL : ~VS_POL;
        de_d          = (h_cnt_q >= HA_C) && (h_cnt_q < HE_C) && req_v;
        frame_start_d = (h_cnt_q == HA_C) && (v_cnt_q == VA_C);
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [CNT_W-1:0] BAR_LAST_C = CNT_W'(H_VALID / 8 - 1);

    logic [2:0]       bar_q, bar_d, cur_bar;
    logic [CNT_W-1:0] bpx_q, bpx_d, cur_px;
    logic [RGB_W-1:0] pat_rgb;

    // Bar position restarts on the first active pixel of every line; leftover columns stay on bar 7.
    always_comb begin
        cur_bar = (h_cnt_q == HA_C) ? 3'd0 : bar_q;
        cur_px  = (h_cnt_q == HA_C) ? '0 : bpx_q;
        bar_d   = bar_q;
        bpx_d   = bpx_q;
        if (de_d) begin
            if ((cur_px == BAR_LAST_C) && (cur_bar != 3'd7)) begin
                bar_d = cur_bar + 3'd1;
                bpx_d = '0;
            end else begin
                bar_d = cur_bar;
                bpx_d = cur_px + CNT_W'(1);
            end
        end
    end

    always_comb begin
        case (cur_bar)
            3'd0:    pat_rgb = RGB_W'(16'hFFFF);
            3'd1:    pat_rgb = RGB_W'(16'hFFE0);
            3'd2:    pat_rgb = RGB_W'(16'h07FF);
            3'd3:    pat_rgb = RGB_W'(16'h07E0);
            3'd4:    pat_rgb = RGB_W'(16'hF81F);
            3'd5:    pat_rgb = RGB_W'(16'hF800);
            3'd6:    pat_rgb = RGB_W'(16'h001F);
            default: pat_rgb = RGB_W'(16'h0000);
        endcase
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bar_q <= '0;
            bpx_q <= '0;
        end else begin
            bar_q <= bar_d;
            bpx_q <= bpx_d;
        end
    end
`endif

    always_comb begin
        rgb_d = '0;
        if (de_d) begin
`ifdef VGA_TEST_PATTERN_EN
            rgb_d = pat_en ? pat_rgb : pix_data;
`else
            rgb_d = pix_data;
`endif
        end
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            de_q          <= 1'b0;
            rgb_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign rgb         = rgb_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: two small-geometry instances (LEAD=0 active-high syncs, LEAD=2 active-low syncs).
// With VGA_TEST_PATTERN_EN defined the colour-bar pattern on the LEAD=2 instance is also checked.

module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int n_cyc;

    // dut0: H 4/2/8/2 (16), V 1/1/3/1 (6), active-high syncs, LEAD=0, HA=6, VA=2
    logic [15:0] pix_data0;
    logic        pix_req0, hsync0, vsync0, de0, fs0;
    logic [11:0] pix_x0, pix_y0;
    logic [15:0] rgb0;
    // dut2: H 3/3/20/2 (28), V 1/2/4/1 (8), active-low syncs, LEAD=2, HA=6, VA=3
    logic [15:0] pix_data2, p1;
    logic        pix_req2, hsync2, vsync2, de2, fs2;
    logic [11:0] pix_x2, pix_y2;
    logic [15:0] rgb2;
`ifdef VGA_TEST_PATTERN_EN
    logic        pat_en0 = 1'b0;
    logic        pat_en2 = 1'b0;
    logic [15:0] bar_tbl [8];
`endif

    // LEAD=0 source is combinational; LEAD=2 source echoes pix_x through two registers.
    assign pix_data0 = {pix_y0[7:0], pix_x0[7:0]};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_cyc     <= 0;
            p1        <= '0;
            pix_data2 <= '0;
        end else begin
            n_cyc     <= n_cyc + 1;
            p1        <= {4'b0, pix_x2};
            pix_data2 <= p1;
        end
    end

    vga_timing_gen #(
        .H_SYNC(4), .H_BACK(2), .H_VALID(8), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_VALID(3), .V_FRONT(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .LEAD(0), .RGB_W(16), .CNT_W(12)
    ) dut0 (
        .vga_clk(clk), .sys_rst_n(rst_n),
`ifdef VGA_TEST_PATTERN_EN
        .pat_en(pat_en0),
`endif
        .pix_data(pix_data0), .pix_req(pix_req0), .pix_x(pix_x0), .pix_y(pix_y0),
        .hsync(hsync0), .vsync(vsync0), .de(de0), .rgb(rgb0), .frame_start(fs0)
    );

    vga_timing_gen #(
        .H_SYNC(3), .H_BACK(3), .H_VALID(20), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(2), .V_VALID(4), .V_FRONT(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .LEAD(2), .RGB_W(16), .CNT_W(12)
    ) dut2 (
        .vga_clk(clk), .sys_rst_n(rst_n),
`ifdef VGA_TEST_PATTERN_EN
        .pat_en(pat_en2),
`endif
        .pix_data(pix_data2), .pix_req(pix_req2), .pix_x(pix_x2), .pix_y(pix_y2),
        .hsync(hsync2), .vsync(vsync2), .de(de2), .rgb(rgb2), .frame_start(fs2)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (hsync0 !== 1'b0) begin bad++; $display("FAIL rst_hsync0 got=%b exp=0", hsync0); end
        total++; if (vsync0 !== 1'b0) begin bad++; $display("FAIL rst_vsync0 got=%b exp=0", vsync0); end
        total++; if (hsync2 !== 1'b1) begin bad++; $display("FAIL rst_hsync2 got=%b exp=1", hsync2); end
        total++; if (vsync2 !== 1'b1) begin bad++; $display("FAIL rst_vsync2 got=%b exp=1", vsync2); end
        total++; if (de0 !== 1'b0 || de2 !== 1'b0) begin bad++; $display("FAIL rst_de got=%b%b exp=00", de0, de2); end
        total++; if (rgb0 !== 16'h0 || rgb2 !== 16'h0) begin bad++; $display("FAIL rst_rgb got=%h/%h exp=0", rgb0, rgb2); end
        total++; if (fs0 !== 1'b0 || fs2 !== 1'b0) begin bad++; $display("FAIL rst_fs got=%b%b exp=00", fs0, fs2); end
        total++; if (pix_req2 !== 1'b0 || pix_x2 !== 12'd0 || pix_y2 !== 12'd0) begin
            bad++; $display("FAIL rst_req2 got=%b x=%0d y=%0d exp=0", pix_req2, pix_x2, pix_y2);
        end
        total++; if (pix_req0 !== 1'b0 || pix_x0 !== 12'd0 || pix_y0 !== 12'd0) begin
            bad++; $display("FAIL rst_req0 got=%b x=%0d y=%0d exp=0", pix_req0, pix_x0, pix_y0);
        end
    endtask

    // Release at a falling edge; the next rising edge must present the h_cnt=0 decode (both syncs active).
    task automatic test_release();
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (hsync0 !== 1'b1 || vsync0 !== 1'b1) begin bad++; $display("FAIL rel_sync0 got=%b%b exp=11", hsync0, vsync0); end
        total++; if (hsync2 !== 1'b0 || vsync2 !== 1'b0) begin bad++; $display("FAIL rel_sync2 got=%b%b exp=00", hsync2, vsync2); end
        total++; if (de0 !== 1'b0 || fs0 !== 1'b0) begin bad++; $display("FAIL rel_de0 got=%b%b exp=00", de0, fs0); end
    endtask

    task automatic test_timing(input int frames);
        int t, h, v, hc, vc, de_n, fs_n, hs_n, vs_n;
        logic e_de, e_hs, e_vs, e_fs, e_req;
        logic [15:0] e_rgb;
        logic [11:0] e_px, e_py;
        de_n = 0; fs_n = 0; hs_n = 0; vs_n = 0;
        for (int i = 0; i < 96 * frames; i++) begin
            @(negedge clk);
            t = n_cyc - 1; h = t % 16; v = (t / 16) % 6;
            e_de  = (h >= 6) && (h < 14) && (v >= 2) && (v < 5);
            e_hs  = (h < 4);
            e_vs  = (v < 1);
            e_fs  = (h == 6) && (v == 2);
            e_rgb = e_de ? 16'((v - 2) * 256 + (h - 6)) : 16'h0;
            hc = n_cyc % 16; vc = (n_cyc / 16) % 6;
            e_req = (hc >= 6) && (hc < 14) && (vc >= 2) && (vc < 5);
            e_px  = e_req ? 12'(hc - 6) : 12'd0;
            e_py  = e_req ? 12'(vc - 2) : 12'd0;
            total++; if (hsync0 !== e_hs) begin bad++; $display("FAIL t_hsync t=%0d got=%b exp=%b", t, hsync0, e_hs); end
            total++; if (vsync0 !== e_vs) begin bad++; $display("FAIL t_vsync t=%0d got=%b exp=%b", t, vsync0, e_vs); end
            total++; if (de0 !== e_de) begin bad++; $display("FAIL t_de t=%0d got=%b exp=%b", t, de0, e_de); end
            total++; if (fs0 !== e_fs) begin bad++; $display("FAIL t_fs t=%0d got=%b exp=%b", t, fs0, e_fs); end
            total++; if (rgb0 !== e_rgb) begin bad++; $display("FAIL t_rgb t=%0d got=%h exp=%h", t, rgb0, e_rgb); end
            total++; if (pix_req0 !== e_req) begin bad++; $display("FAIL t_req n=%0d got=%b exp=%b", n_cyc, pix_req0, e_req); end
            total++; if (pix_x0 !== e_px || pix_y0 !== e_py) begin
                bad++; $display("FAIL t_xy n=%0d got=%0d,%0d exp=%0d,%0d", n_cyc, pix_x0, pix_y0, e_px, e_py);
            end
            if (de0 === 1'b1) de_n++;
            if (fs0 === 1'b1) fs_n++;
            if (hsync0 === 1'b1) hs_n++;
            if (vsync0 === 1'b1) vs_n++;
        end
        total++; if (de_n != 24 * frames) begin bad++; $display("FAIL t_de_count got=%0d exp=%0d", de_n, 24 * frames); end
        total++; if (fs_n != frames) begin bad++; $display("FAIL t_fs_count got=%0d exp=%0d", fs_n, frames); end
        total++; if (hs_n != 24 * frames) begin bad++; $display("FAIL t_hs_count got=%0d exp=%0d", hs_n, 24 * frames); end
        total++; if (vs_n != 16 * frames) begin bad++; $display("FAIL t_vs_count got=%0d exp=%0d", vs_n, 16 * frames); end
    endtask

    task automatic test_lead(input int frames);
        int t, h, v, hc, vc, de_n;
        logic e_de, e_hs, e_vs, e_fs, e_req;
        logic [15:0] e_rgb;
        logic [11:0] e_px, e_py;
        de_n = 0;
        for (int i = 0; i < 224 * frames; i++) begin
            @(negedge clk);
            t = n_cyc - 1; h = t % 28; v = (t / 28) % 8;
            e_de  = (h >= 6) && (h < 26) && (v >= 3) && (v < 7);
            e_hs  = !(h < 3);
            e_vs  = !(v < 1);
            e_fs  = (h == 6) && (v == 3);
            e_rgb = e_de ? 16'(h - 6) : 16'h0;
            hc = n_cyc % 28; vc = (n_cyc / 28) % 8;
            e_req = (hc >= 4) && (hc < 24) && (vc >= 3) && (vc < 7);
            e_px  = e_req ? 12'(hc - 4) : 12'd0;
            e_py  = e_req ? 12'(vc - 3) : 12'd0;
            total++; if (hsync2 !== e_hs || vsync2 !== e_vs) begin
                bad++; $display("FAIL l_sync t=%0d got=%b%b exp=%b%b", t, hsync2, vsync2, e_hs, e_vs);
            end
            total++; if (de2 !== e_de || fs2 !== e_fs) begin
                bad++; $display("FAIL l_de_fs t=%0d got=%b%b exp=%b%b", t, de2, fs2, e_de, e_fs);
            end
            total++; if (rgb2 !== e_rgb) begin bad++; $display("FAIL l_rgb t=%0d got=%0d exp=%0d", t, rgb2, e_rgb); end
            total++; if (pix_req2 !== e_req || pix_x2 !== e_px || pix_y2 !== e_py) begin
                bad++; $display("FAIL l_req n=%0d got=%b %0d,%0d exp=%b %0d,%0d", n_cyc, pix_req2, pix_x2, pix_y2, e_req, e_px, e_py);
            end
            if (de2 === 1'b1) de_n++;
        end
        total++; if (de_n != 80 * frames) begin bad++; $display("FAIL l_de_count got=%0d exp=%0d", de_n, 80 * frames); end
    endtask

    // Reset lands asynchronously in the middle of an active line of dut0.
    task automatic test_reset_mid();
        int guard;
        guard = 0;
        while (!(((n_cyc - 1) % 16 == 8) && (((n_cyc - 1) / 16) % 6 == 3)) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        total++; if (guard >= 200) begin bad++; $display("FAIL mid_seek got=%0d exp<200", guard); end
        total++; if (de0 !== 1'b1) begin bad++; $display("FAIL mid_pre_de got=%b exp=1", de0); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (de0 !== 1'b0 || rgb0 !== 16'h0 || fs0 !== 1'b0) begin
            bad++; $display("FAIL mid_async_out got=%b %h %b exp=0 0 0", de0, rgb0, fs0);
        end
        total++; if (hsync0 !== 1'b0 || vsync0 !== 1'b0) begin bad++; $display("FAIL mid_async_sync0 got=%b%b exp=00", hsync0, vsync0); end
        total++; if (hsync2 !== 1'b1 || vsync2 !== 1'b1) begin bad++; $display("FAIL mid_async_sync2 got=%b%b exp=11", hsync2, vsync2); end
        total++; if (pix_req0 !== 1'b0 || pix_x0 !== 12'd0 || pix_y0 !== 12'd0) begin
            bad++; $display("FAIL mid_async_req got=%b %0d,%0d exp=0", pix_req0, pix_x0, pix_y0);
        end
        repeat (3) @(negedge clk);
        total++; if (de0 !== 1'b0 || hsync0 !== 1'b0) begin bad++; $display("FAIL mid_hold got=%b%b exp=00", de0, hsync0); end
        test_release();
        test_timing(1);
        test_lead(1);
    endtask

`ifdef VGA_TEST_PATTERN_EN
    task automatic test_pattern();
        int t, h, v, b;
        logic [15:0] e_rgb;
        pat_en2 = 1'b1;
        for (int i = 0; i < 224; i++) begin
            @(negedge clk);
            t = n_cyc - 1; h = t % 28; v = (t / 28) % 8;
            if ((h >= 6) && (h < 26) && (v >= 3) && (v < 7)) begin
                b = (h - 6) / 2;
                if (b > 7) b = 7;
                e_rgb = pat_en2 ? bar_tbl[b] : 16'(h - 6);
            end else begin
                e_rgb = 16'h0;
            end
            total++; if (rgb2 !== e_rgb) begin bad++; $display("FAIL p_rgb t=%0d pat=%b got=%h exp=%h", t, pat_en2, rgb2, e_rgb); end
            if (v == 4 && h == 12) pat_en2 = 1'b0;
            if (v == 4 && h == 18) pat_en2 = 1'b1;
        end
        pat_en2 = 1'b0;
    endtask
`endif

    initial begin
`ifdef VGA_TEST_PATTERN_EN
        bar_tbl[0] = 16'hFFFF; bar_tbl[1] = 16'hFFE0; bar_tbl[2] = 16'h07FF; bar_tbl[3] = 16'h07E0;
        bar_tbl[4] = 16'hF81F; bar_tbl[5] = 16'hF800; bar_tbl[6] = 16'h001F; bar_tbl[7] = 16'h0000;
`endif
        test_reset();
        test_release();
        test_timing(2);
        test_lead(2);
`ifdef VGA_TEST_PATTERN_EN
        test_pattern();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
